// File: rtl/best_match_if.sv
// best_match_if: candidate readout bus between the accumulator, the best-match picker and its consumer.
// no_match is present only when BEST_MATCH_THRESH_EN is defined.
interface best_match_if;
    logic               start;
    logic [13:0]        g2sum;
    logic [10:0]        gsum;
    logic [13:0]        fg;
    logic [5:0]         place;
    logic               finalstart;
    logic               valid;
    logic               busy;
    logic               done;
    logic [5:0]         best_place;
    logic signed [15:0] best_cost;
    logic [10:0]        best_gsum;
`ifdef BEST_MATCH_THRESH_EN
    logic               no_match;
`endif

    modport slave (
        input  start, g2sum, gsum, fg, place,
        output finalstart, valid, busy, done, best_place, best_cost, best_gsum
`ifdef BEST_MATCH_THRESH_EN
        , output no_match
`endif
    );

    modport master (
        output start, g2sum, gsum, fg, place,
        input  finalstart, valid, busy, done, best_place, best_cost, best_gsum
`ifdef BEST_MATCH_THRESH_EN
        , input no_match
`endif
    );
endinterface

// File: rtl/best_match.sv
// best_match: walks the four accumulated candidates and keeps the lowest g2sum - 2*fg cost.
// Optional BEST_MATCH_THRESH_EN adds no_match = (best_cost > THRESH), latched at the done transition.
module best_match #(
    parameter logic signed [15:0] THRESH = 16'sd0
) (
    input  logic       clk,
    input  logic       rst_n,
    best_match_if.slave bm
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FS   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_ADV  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         r_state;
    logic [1:0]         r_idx;
    logic               r_finalstart;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;
    logic [5:0]         r_best_place;
    logic signed [15:0] r_best_cost;
    logic [10:0]        r_best_gsum;

    logic signed [15:0] w_cost;
    logic               w_take;
    logic signed [15:0] w_best_cost_nxt;

    // 16 bits covers +16383 down to -32766, so the subtraction never wraps
    assign w_cost          = $signed({2'b00, bm.g2sum}) - $signed({1'b0, bm.fg, 1'b0});
    assign w_take          = (r_state == S_CAP) && ((r_idx == 2'd0) || (w_cost < r_best_cost));
    assign w_best_cost_nxt = w_take ? w_cost : r_best_cost;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= 2'd0;
            r_finalstart <= 1'b0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bm.start) begin
                        r_state      <= S_FS;
                        r_idx        <= 2'd0;
                        r_finalstart <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_FS: begin
                    r_finalstart <= 1'b0;
                    r_state      <= S_CAP;
                end
                S_CAP: begin
                    r_state <= (r_idx == 2'd3) ? S_DONE : S_ADV;
                    r_valid <= (r_idx != 2'd3);
                    r_done  <= (r_idx == 2'd3);
                    r_busy  <= (r_idx != 2'd3);
                end
                S_ADV: begin
                    r_valid <= 1'b0;
                    r_idx   <= r_idx + 2'd1;
                    r_state <= S_CAP;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // winner registers move only on capture edges; ties keep the earlier candidate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_place <= 6'd0;
            r_best_cost  <= 16'sd0;
            r_best_gsum  <= 11'd0;
        end else if (w_take) begin
            r_best_place <= bm.place;
            r_best_cost  <= w_cost;
            r_best_gsum  <= bm.gsum;
        end
    end

`ifdef BEST_MATCH_THRESH_EN
    logic r_no_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_no_match <= 1'b0;
        else if (r_state == S_CAP && r_idx == 2'd3)
            r_no_match <= (w_best_cost_nxt > THRESH);
    end

    assign bm.no_match = r_no_match;
`else
    logic w_unused_thresh;
    assign w_unused_thresh = ^{THRESH, w_best_cost_nxt};
`endif

    assign bm.finalstart = r_finalstart;
    assign bm.valid      = r_valid;
    assign bm.busy       = r_busy;
    assign bm.done       = r_done;
    assign bm.best_place = r_best_place;
    assign bm.best_cost  = r_best_cost;
    assign bm.best_gsum  = r_best_gsum;
endmodule

// File: tb/tb_best_match.sv
// tb_best_match: directed readouts against a small accumulator model feeding candidates by index.
module tb_best_match;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    best_match_if bm ();
    best_match #(.THRESH(16'sd0)) dut (.clk(clk), .rst_n(rst_n), .bm(bm));

    always #5 clk = ~clk;

    logic [13:0] c_g2 [4];
    logic [13:0] c_fg [4];
    logic [10:0] c_gs [4];
    logic [5:0]  c_pl [4];
    logic [1:0]  ptr = 2'd0;

    always @(posedge clk) begin
        if (bm.finalstart) ptr <= 2'd0;
        else if (bm.valid) ptr <= ptr + 2'd1;
    end

    always_comb begin
        bm.g2sum = c_g2[ptr];
        bm.fg    = c_fg[ptr];
        bm.gsum  = c_gs[ptr];
        bm.place = c_pl[ptr];
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_cand(input int i, input int g2, input int fg, input int gs, input int pl);
        c_g2[i] = 14'(g2);
        c_fg[i] = 14'(fg);
        c_gs[i] = 11'(gs);
        c_pl[i] = 6'(pl);
    endtask

    // start at edge 0, then record per-cycle pulse masks until done or the budget expires
    task automatic readout(input bit poke, output int dc, output logic [15:0] fsm,
                           output logic [15:0] vm, output logic [15:0] bsy, output int ovl);
        dc = -1; fsm = '0; vm = '0; bsy = '0; ovl = 0;
        @(negedge clk);
        bm.start = 1'b1;
        for (int c = 1; c <= 20 && dc < 0; c++) begin
            @(negedge clk);
            bm.start = poke && c >= 3 && c <= 5;
            fsm[c[3:0]] = bm.finalstart;
            vm[c[3:0]]  = bm.valid;
            bsy[c[3:0]] = bm.busy;
            if (bm.finalstart && bm.valid) ovl++;
            if (bm.done) dc = c;
        end
        bm.start = 1'b0;
    endtask

    int          dc, ovl, seen_done;
    logic [15:0] fsm, vm, bsy;

    initial begin
        bm.start = 1'b0;
        for (int i = 0; i < 4; i++) set_cand(i, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_busy", bm.busy, 0);
        chk("rst_done", bm.done, 0);
        chk("rst_fs", bm.finalstart, 0);
        chk("rst_valid", bm.valid, 0);
        chk("rst_place", bm.best_place, 0);
        chk("rst_cost", bm.best_cost, 0);
        rst_n = 1'b1;

        set_cand(0, 100, 40, 7, 0);
        set_cand(1, 90, 60, 8, 16);
        set_cand(2, 50, 10, 9, 32);
        set_cand(3, 200, 80, 10, 48);
        readout(1'b1, dc, fsm, vm, bsy, ovl);
        chk("a_done_cycle", dc, 9);
        chk("a_fs_mask", fsm, 16'h0002);
        chk("a_valid_mask", vm, 16'h00A8);
        chk("a_busy_mask", bsy, 16'h01FE);
        chk("a_overlap", ovl, 0);
        chk("a_place", bm.best_place, 16);
        chk("a_cost", bm.best_cost, -30);
        chk("a_gsum", bm.best_gsum, 8);
`ifdef BEST_MATCH_THRESH_EN
        chk("a_no_match", bm.no_match, 0);
`endif
        repeat (3) @(negedge clk);
        chk("a_hold_done", bm.done, 0);
        chk("a_hold_busy", bm.busy, 0);
        chk("a_hold_place", bm.best_place, 16);
        chk("a_hold_cost", bm.best_cost, -30);

        set_cand(0, 5, 0, 21, 3);
        set_cand(1, 7, 1, 22, 4);
        set_cand(2, 25, 10, 23, 5);
        set_cand(3, 105, 50, 24, 6);
        readout(1'b0, dc, fsm, vm, bsy, ovl);
        chk("tie_done_cycle", dc, 9);
        chk("tie_place", bm.best_place, 3);
        chk("tie_cost", bm.best_cost, 5);
        chk("tie_gsum", bm.best_gsum, 21);
`ifdef BEST_MATCH_THRESH_EN
        chk("tie_no_match", bm.no_match, 1);
`endif

        for (int i = 0; i < 4; i++) set_cand(i, 16383, 0, 100 + i, 40 + i);
        readout(1'b0, dc, fsm, vm, bsy, ovl);
        chk("max_cost", bm.best_cost, 16383);
        chk("max_place", bm.best_place, 40);

        set_cand(2, 0, 16383, 2047, 63);
        readout(1'b0, dc, fsm, vm, bsy, ovl);
        chk("min_cost", bm.best_cost, -32766);
        chk("min_place", bm.best_place, 63);
        chk("min_gsum", bm.best_gsum, 2047);

        set_cand(0, 100, 40, 7, 0);
        set_cand(1, 90, 60, 8, 16);
        set_cand(2, 50, 10, 9, 32);
        set_cand(3, 200, 80, 10, 48);
        @(negedge clk);
        bm.start = 1'b1;
        @(negedge clk);
        bm.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bm.busy, 0);
        chk("mid_rst_valid", bm.valid, 0);
        chk("mid_rst_fs", bm.finalstart, 0);
        chk("mid_rst_place", bm.best_place, 0);
        chk("mid_rst_cost", bm.best_cost, 0);
        chk("mid_rst_gsum", bm.best_gsum, 0);
        seen_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bm.done) seen_done++;
        end
        chk("mid_rst_no_done", seen_done, 0);
        rst_n = 1'b1;
        readout(1'b0, dc, fsm, vm, bsy, ovl);
        chk("post_rst_done_cycle", dc, 9);
        chk("post_rst_place", bm.best_place, 16);
        chk("post_rst_cost", bm.best_cost, -30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/best_match.md
BEST_MATCH -- requirements
Module: best_match

Interface
REQ-001 Parameter THRESH, default 16'sd0: signed 16-bit cost ceiling, used only when BEST_MATCH_THRESH_EN is defined.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port start, input, 1: request one readout of the four accumulated candidates; sampled only in IDLE.
REQ-005 Port g2sum, input, 14: candidate sum of g squared, from the accumulator unit.
REQ-006 Port gsum, input, 11: candidate sum of g; captured and passed to best_gsum.
REQ-007 Port fg, input, 14: candidate sum of f*g.
REQ-008 Port place, input, 6: candidate disparity/place tag.
REQ-009 Port finalstart, output, 1: one-cycle pulse that rewinds the accumulator readout to candidate 0.
REQ-010 Port valid, output, 1: one-cycle pulse that advances the accumulator readout to the next candidate.
REQ-011 Port busy, output, 1: high from the cycle after start is accepted until done is asserted.
REQ-012 Port done, output, 1: one-cycle pulse; best_* outputs are valid from this cycle on.
REQ-013 Port best_place, output, 6: place tag of the winning candidate.
REQ-014 Port best_cost, output, 16 signed: cost of the winning candidate.
REQ-015 Port best_gsum, output, 11: gsum of the winning candidate.
REQ-016 Port no_match, output, 1: winner cost exceeds THRESH; exists only with BEST_MATCH_THRESH_EN.

Function
REQ-017 The block SHALL implement the states IDLE, FS, CAP, ADV and DONE, with a 2-bit candidate index idx.
REQ-018 IDLE with start=1 SHALL go to FS and clear idx; start in any other state SHALL be ignored.
REQ-019 FS SHALL drive finalstart=1 for exactly one cycle, then go to CAP.
REQ-020 CAP SHALL register g2sum, gsum, fg and place, compute the cost and compare it; then go to ADV if idx<3, else DONE.
REQ-021 ADV SHALL drive valid=1 for exactly one cycle, increment idx, then go to CAP.
REQ-022 DONE SHALL drive done=1 for one cycle, then return to IDLE.
REQ-023 Timing, with start sampled at edge 0: finalstart high in cycle 1; captures at edges 2, 4, 6, 8; valid high in cycles 3, 5, 7; done high in cycle 9.
REQ-024 finalstart and valid SHALL be registered outputs, glitch-free, never high together.
REQ-025 Cost SHALL be signed 16-bit: zero-extend(g2sum) - 2*zero-extend(fg), computed without overflow.
REQ-026 Candidate 0 SHALL always load the best registers; a later candidate SHALL replace the best only when its cost is strictly lower.
REQ-027 On equal cost, the lower-index candidate SHALL win.
REQ-028 best_* SHALL update only at CAP edges, hold their values after done, and be overwritten by the next readout.

Reset
REQ-029 With rst_n=0, immediately and independent of clk: state=IDLE, idx=0, finalstart=0, valid=0, busy=0, done=0, best_place=0, best_cost=0, best_gsum=0, no_match=0.
REQ-030 Reset asserted mid-readout SHALL abort the readout with no done pulse; the first start after release SHALL run a full readout.

Configuration
REQ-031 With macro BEST_MATCH_THRESH_EN defined, no_match SHALL be registered at the DONE transition as (best_cost > THRESH) and held until the next done.
REQ-032 With BEST_MATCH_THRESH_EN undefined, the no_match port and its logic SHALL be absent, and THRESH SHALL have no effect.

Verification
REQ-033 Candidates (g2sum, fg, place) = (100,40,0), (90,60,16), (50,10,32), (200,80,48) -> costs 20, -30, 30, 40; done in cycle 9 with best_place=16, best_cost=-30.
REQ-034 All four candidates have cost 5 -> best_place equals candidate 0's place (tie rule).
REQ-035 Pulse check: exactly one finalstart then three valid pulses, each one cycle wide, none overlapping; start pulses while busy have no effect.
REQ-036 Extremes g2sum=16383, fg=0 and g2sum=0, fg=16383 -> costs +16383 and -32766, no wrap.
REQ-037 rst_n dropped in cycle 5 -> all outputs 0 at once, no done; a new start then gives done 9 cycles later.
REQ-038 With BEST_MATCH_THRESH_EN and THRESH=0: the REQ-033 set gives no_match=0; all costs positive gives no_match=1.
